// File: rtl/rice_encoder_pkg.sv
// Shared constants and FSM encoding for the FLAC Rice encode path.
// The escape value and residual width match the decoder side.
package rice_encoder_pkg;

  localparam int FLAC_RESIDUAL_WIDTH = 16;
  localparam int FLAC_RICE_ESCAPE    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UNARY = 2'd1,
    ST_STOP  = 2'd2,
    ST_REM   = 2'd3
  } state_t;

endpackage

// File: rtl/rice_fold.sv
// Zigzag fold of a signed residual and quotient/remainder split by k; purely combinational.
// No latency, no flow control; reusable by the Rice parameter estimator.
module rice_fold #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARAM_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]  v_i,
  input  logic [PARAM_WIDTH-1:0] k_i,
  output logic [DATA_WIDTH-1:0]  q_o,
  output logic [DATA_WIDTH-2:0]  r_o
);

  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-2:0] mask;

  // -2v-1 == ~(2v) in two's complement, so the fold is a shift and conditional invert
  assign u    = {v_i[DATA_WIDTH-2:0], 1'b0} ^ {DATA_WIDTH{v_i[DATA_WIDTH-1]}};
  assign mask = ((DATA_WIDTH-1)'(1) << k_i) - (DATA_WIDTH-1)'(1);
  assign q_o  = u >> k_i;
  assign r_o  = u[DATA_WIDTH-2:0] & mask;

endmodule

// File: rtl/rice_encoder.sv
// Serial Rice encoder: one residual in, codeword out one bit per cycle MSB first.
// First bit one cycle after accept; bits hold while iBitReady is low; one idle cycle between codewords.
module rice_encoder
  import rice_encoder_pkg::*;
#(
  parameter int DATA_WIDTH  = FLAC_RESIDUAL_WIDTH,
  parameter int PARAM_WIDTH = 4
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic [DATA_WIDTH-1:0]  iData,
  input  logic [PARAM_WIDTH-1:0] iRiceParam,
  input  logic                   iValid,
  output logic                   oReady,
  output logic                   oBit,
  output logic                   oBitValid,
  input  logic                   iBitReady,
  output logic                   oDone,
  output logic                   oParamErr
);

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   bit_q, bit_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic                   perr_q, perr_d;
  logic [DATA_WIDTH-1:0]  qcnt_q, qcnt_d;
  logic [DATA_WIDTH-2:0]  rem_q, rem_d;
  logic [PARAM_WIDTH-1:0] k_q, k_d;
  logic [PARAM_WIDTH-1:0] idx_q, idx_d;

  logic [DATA_WIDTH-1:0]  fold_q;
  logic [DATA_WIDTH-2:0]  fold_r;
  logic                   accept;
  logic                   escape;
  logic                   xfer;
  logic [PARAM_WIDTH-1:0] k_m1;
  logic [PARAM_WIDTH-1:0] idx_m1;

  rice_fold #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARAM_WIDTH(PARAM_WIDTH)
  ) u_fold (
    .v_i(iData),
    .k_i(iRiceParam),
    .q_o(fold_q),
    .r_o(fold_r)
  );

  assign accept = ready_q & iValid;
  assign escape = (iRiceParam == PARAM_WIDTH'(FLAC_RICE_ESCAPE));
  assign xfer   = vld_q & iBitReady;
  assign k_m1   = k_q - PARAM_WIDTH'(1);
  assign idx_m1 = idx_q - PARAM_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    bit_d   = bit_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    qcnt_d  = qcnt_q;
    rem_d   = rem_q;
    k_d     = k_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (escape) begin
            perr_d = 1'b1;
          end else begin
            qcnt_d  = fold_q;
            rem_d   = fold_r;
            k_d     = iRiceParam;
            ready_d = 1'b0;
            vld_d   = 1'b1;
            if (fold_q != '0) begin
              state_d = ST_UNARY;
              bit_d   = 1'b0;
            end else begin
              state_d = ST_STOP;
              bit_d   = 1'b1;
            end
          end
        end
      end
      ST_UNARY: begin
        if (xfer) begin
          if (qcnt_q == DATA_WIDTH'(1)) begin
            state_d = ST_STOP;
            bit_d   = 1'b1;
          end else begin
            qcnt_d = qcnt_q - DATA_WIDTH'(1);
          end
        end
      end
      ST_STOP: begin
        if (xfer) begin
          if (k_q != '0) begin
            state_d = ST_REM;
            idx_d   = k_m1;
            bit_d   = rem_q[k_m1];
          end else begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            bit_d   = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      ST_REM: begin
        if (xfer) begin
          if (idx_q == '0) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            bit_d   = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_m1;
            bit_d = rem_q[idx_m1];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      qcnt_q  <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      qcnt_q  <= qcnt_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
    end
  end

  assign oReady    = ready_q;
  assign oBit      = bit_q;
  assign oBitValid = vld_q;
  assign oDone     = done_q;
  assign oParamErr = perr_q;

endmodule

// File: tb/tb_rice_encoder.sv
// Bench for rice_encoder: directed and random residuals checked against a codeword model.
module tb_rice_encoder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data  = '0;
  logic [3:0]  k_in  = '0;
  logic        valid = 1'b0;
  logic        brdy  = 1'b1;
  logic        oReady, oBit, oBitValid, oDone, oParamErr;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];
  bit exp_done  = 1'b0;
  bit exp_perr  = 1'b0;
  bit stall     = 1'b0;
  bit stall_bit = 1'b0;
  bit bp_mode   = 1'b0;
  int rel_cnt   = 0;

  rice_encoder dut (
    .iClock    (clk),
    .iReset_n  (rst_n),
    .iData     (data),
    .iRiceParam(k_in),
    .iValid    (valid),
    .oReady    (oReady),
    .oBit      (oBit),
    .oBitValid (oBitValid),
    .iBitReady (brdy),
    .oDone     (oDone),
    .oParamErr (oParamErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int fold(input int v);
    return (v >= 0) ? 2 * v : -2 * v - 1;
  endfunction

  function automatic int cw_len(input int v, input int k);
    return (fold(v) >> k) + 1 + k;
  endfunction

  function automatic bit cw_bit(input int v, input int k, input int i);
    int u;
    int q;
    int r;
    u = fold(v);
    q = u >> k;
    r = u % (1 << k);
    if (i < q) return 1'b0;
    if (i == q) return 1'b1;
    return bit'((r >> (k - 1 - (i - q - 1))) & 1);
  endfunction

  function automatic longint cw_pack(input int v, input int k);
    longint a;
    a = 0;
    for (int i = 0; i < cw_len(v, k); i++) a = (a << 1) | longint'(cw_bit(v, k, i));
    return a;
  endfunction

  // Compare process: every outputs-meaningful cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", int'(oReady), 0);
      chk("rst_bitvalid", int'(oBitValid), 0);
      chk("rst_bit", int'(oBit), 0);
      chk("rst_done", int'(oDone), 0);
      chk("rst_paramerr", int'(oParamErr), 0);
      exp_q.delete();
      exp_done = 1'b0;
      exp_perr = 1'b0;
      stall    = 1'b0;
      rel_cnt  = 0;
    end else begin
      if (rel_cnt < 2) rel_cnt++;
      chk("done", int'(oDone), int'(exp_done));
      chk("paramerr", int'(oParamErr), int'(exp_perr));
      chk("ready", int'(oReady), int'(rel_cnt >= 2 && exp_q.size() == 0));
      exp_done = 1'b0;
      exp_perr = 1'b0;
      if (stall) begin
        chk("stall_valid", int'(oBitValid), 1);
        chk("stall_bit", int'(oBit), int'(stall_bit));
      end
      stall     = oBitValid && !brdy;
      stall_bit = oBit;
      if (exp_q.size() != 0) begin
        chk("bitvalid", int'(oBitValid), 1);
        if (oBitValid) begin
          chk("bit", int'(oBit), int'(exp_q[0]));
          if (brdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
      end else begin
        chk("idle_bitvalid", int'(oBitValid), 0);
      end
      if (valid && oReady) begin
        if (k_in == 4'd15) begin
          exp_perr = 1'b1;
        end else begin
          for (int i = 0; i < cw_len(int'($signed(data)), int'(k_in)); i++)
            exp_q.push_back(cw_bit(int'($signed(data)), int'(k_in), i));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      brdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int v, input int k);
    bit ok;
    ok    = 1'b0;
    data  = 16'(v);
    k_in  = 4'(k);
    valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (oReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_wait", int'(ok), 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && oReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_wait", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rv;
    int rk;
    chk("pin_len_v1k0", cw_len(1, 0), 3);
    chk("pin_bits_v1k0", int'(cw_pack(1, 0)), 1);
    chk("pin_bits_v7k3", int'(cw_pack(7, 3)), 14);
    chk("pin_len_vm102k3", cw_len(-102, 3), 29);
    chk("pin_bits_vm102k3", int'(cw_pack(-102, 3)), 11);
    chk("pin_len_vmink14", cw_len(-32768, 14), 18);
    chk("pin_bits_vmink14", int'(cw_pack(-32768, 14)), 32767);
    chk("pin_bits_v50k3", int'(cw_pack(50, 3)), 12);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(1, 0);
    wait_idle();
    send(7, 3);
    send(-102, 3);
    wait_idle();
    send(-32768, 14);
    wait_idle();

    bp_mode = 1'b1;
    send(50, 3);
    wait_idle();
    bp_mode = 1'b0;

    send(300, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, 0);
    wait_idle();

    send(5, 15);
    repeat (3) @(posedge clk);
    #1;
    send(32767, 14);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      rk = int'($urandom_range(0, 15));
      rv = int'($signed(16'($urandom)));
      if (rk < 8) rv = rv >>> (8 - rk);
      bp_mode = 1'($urandom_range(0, 1));
      send(rv, rk);
    end
    wait_idle();
    bp_mode = 1'b0;

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
